mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/MEM-stage clients, the arbiter and the shared memory.
// The arbiter takes the slave view; a client/memory model takes the master view.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_abort_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;

  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  logic        stall_o;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i, if_abort_i,
    output if_ready_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_ready_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, if_abort_i,
    input  if_ready_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_ready_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  stall_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one single-port memory, with
// fetch-abort kill tracking and a sticky ack-timeout error.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] dm_rdata_q, if_rdata_q;
  logic [9:0]  cnt_q;
  logic        kill_q, err_q;

  logic busy, ack, tmo, fin;

  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);
  assign ack  = busy & bus.mem_ack_i;
  // An ack on the last allowed cycle wins over the timeout.
  assign tmo  = busy & ~bus.mem_ack_i & (cnt_q == TO_LAST);
  assign fin  = ack | tmo;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dm_req_i)                          state_d = BUSY_D;
        else if (bus.if_req_i && !bus.if_abort_i)  state_d = BUSY_I;
      end
      BUSY_D:  if (fin) state_d = DONE_D;
      BUSY_I:  if (fin) state_d = DONE_I;
      DONE_D:  state_d = IDLE;
      DONE_I:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (bus.dm_req_i) begin
          we_q    <= bus.dm_we_i;
          addr_q  <= bus.dm_addr_i;
          wdata_q <= bus.dm_wdata_i;
        end else if (bus.if_req_i && !bus.if_abort_i) begin
          we_q   <= 1'b0;
          addr_q <= bus.if_addr_i;
        end
      end else if (busy && !bus.mem_ack_i) begin
        cnt_q <= cnt_q + 10'd1;
      end

      // The aborted fetch still completes on the bus; only its result is dropped.
      if (state_d == IDLE)
        kill_q <= 1'b0;
      else if (state_q == BUSY_I && bus.if_abort_i)
        kill_q <= 1'b1;

      if (state_q == BUSY_D && fin && !we_q)
        dm_rdata_q <= tmo ? 32'h0 : bus.mem_rdata_i;

      if (state_q == BUSY_I && fin && !kill_q && !bus.if_abort_i)
        if_rdata_q <= tmo ? 32'h0 : bus.mem_rdata_i;

      if (tmo)
        err_q <= 1'b1;
    end
  end

  assign bus.mem_req_o   = busy;
  assign bus.mem_we_o    = busy & we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  assign bus.dm_ready_o  = (state_q == DONE_D);
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ready_o  = (state_q == DONE_I) & ~kill_q & ~bus.if_abort_i;
  assign bus.if_rdata_o  = if_rdata_q;

  assign bus.stall_o = (bus.dm_req_i & ~bus.dm_ready_o) |
                       (bus.if_req_i & ~bus.if_ready_o & ~bus.if_abort_i);
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-mid-access sequence, then
// randomized fetch/data traffic checked against a cycle-window reference model.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(TO)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int lat_q[$];
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  int busy_cyc = 0;
  int cur_lat  = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Each transaction acks after the latency queued for it (lat>=TO never acks).
  always @(negedge clk_i) begin
    if (rst_i || !bus.mem_req_o) begin
      busy_cyc = 0;
      bus.mem_ack_i = 1'b0;
      bus.mem_rdata_i = $urandom;
    end else begin
      if (busy_cyc == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
      if (busy_cyc == cur_lat) begin
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = resp_rd(bus.mem_addr_o);
        if (bus.mem_we_o) resp_mem[bus.mem_addr_o] = bus.mem_wdata_o;
      end else begin
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = $urandom;
      end
      busy_cyc++;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_dr = '0, ref_ir = '0;
  bit ref_err = 1'b0;

  function automatic int eff(input int l);
    return (l > TO - 1) ? TO - 1 : l;
  endfunction

  // Cycle 0 = request presented; BUSY starts in cycle 1 (or after the data
  // access plus one IDLE cycle when both requests arrive together).
  task automatic model(input bit dm, we, fe, input logic [31:0] da, wd, ia,
                       input int ld, li, ab, output int edc, output int eic);
    int si;
    edc = dm ? 2 + eff(ld) : -1;
    si  = dm ? 4 + eff(ld) : 1;
    if (dm) begin
      if (ld > TO - 1) ref_err = 1'b1;
      if (we) begin
        if (ld <= TO - 1) ref_mem[da] = wd;
      end else begin
        ref_dr = (ld > TO - 1) ? 32'h0 : ref_rd(da);
      end
    end
    eic = -1;
    if (fe) begin
      if (li > TO - 1) ref_err = 1'b1;
      if (ab == 0) begin
        eic = si + eff(li) + 1;
        ref_ir = (li > TO - 1) ? 32'h0 : ref_rd(ia);
      end
    end
  endtask

  // ---------------- scenario driver / checker ----------------
  task automatic run_scn(input string nm, input bit dm, we, fe,
                         input logic [31:0] da, wd, ia, input int ld, li, ab,
                         input int edc, eic, input logic [31:0] edr, eir, input bit eerr);
    int ed, ei, si, last, got_dc, got_ic, ndp, nip;
    bit dbusy, ibusy, bus_bad, stall_bad, exp_stall;
    ed = eff(ld);
    ei = eff(li);
    si = dm ? 4 + ed : 1;
    last = fe ? si + ei + 2 : 3 + ed;
    got_dc = -1; got_ic = -1; ndp = 0; nip = 0;
    bus_bad = 1'b0; stall_bad = 1'b0;
    lat_q.delete();
    if (dm) lat_q.push_back(ld);
    if (fe) lat_q.push_back(li);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        bus.dm_req_i = dm; bus.dm_we_i = we; bus.dm_addr_i = da; bus.dm_wdata_i = wd;
        bus.if_req_i = fe; bus.if_addr_i = ia;
      end
      if (got_dc >= 0 && k > got_dc) bus.dm_req_i = 1'b0;
      if (got_ic >= 0 && k > got_ic) bus.if_req_i = 1'b0;
      if (ab > 0 && k == ab) begin
        bus.if_abort_i = 1'b1;
        bus.if_req_i = 1'b0;
      end else begin
        bus.if_abort_i = 1'b0;
      end
      #1;
      dbusy = dm && k >= 1 && k <= 1 + ed;
      ibusy = fe && k >= si && k <= si + ei;
      if (bus.mem_req_o !== (dbusy | ibusy)) bus_bad = 1'b1;
      if (dbusy && (bus.mem_addr_o !== da || bus.mem_we_o !== we ||
                    (we && bus.mem_wdata_o !== wd))) bus_bad = 1'b1;
      if (ibusy && (bus.mem_addr_o !== ia || bus.mem_we_o !== 1'b0)) bus_bad = 1'b1;
      exp_stall = (bus.dm_req_i & ~bus.dm_ready_o) |
                  (bus.if_req_i & ~bus.if_ready_o & ~bus.if_abort_i);
      if (bus.stall_o !== exp_stall) stall_bad = 1'b1;
      if (bus.dm_ready_o === 1'b1) begin ndp++; got_dc = k; end
      if (bus.if_ready_o === 1'b1) begin nip++; got_ic = k; end
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0; bus.if_abort_i = 1'b0;
    chk({nm, ".dm_ready_cycle"}, got_dc, edc);
    chk({nm, ".dm_pulses"}, ndp, (edc >= 0) ? 1 : 0);
    chk({nm, ".if_ready_cycle"}, got_ic, eic);
    chk({nm, ".if_pulses"}, nip, (eic >= 0) ? 1 : 0);
    chk({nm, ".dm_rdata"}, bus.dm_rdata_o, edr);
    chk({nm, ".if_rdata"}, bus.if_rdata_o, eir);
    chk({nm, ".err"}, bus.err_o, eerr);
    chk({nm, ".mem_bus"}, bus_bad, 0);
    chk({nm, ".stall"}, stall_bad, 0);
  endtask

  typedef struct {
    string nm;
    bit dm, we, fe;
    logic [31:0] da, wd, ia;
    int ld, li, ab, edc, eic;
    logic [31:0] edr, eir;
    bit eerr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int edc, eic, mode, ld, li, ab;
    bit dm, we, fe;
    logic [31:0] da, wd, ia;

    tbl[0]  = '{"load_lat3",    1,0,0, 32'h10,  32'h0,    32'h0,   3, 0, 0, 5, -1, 32'hDEADBEEF, 32'h0,  0};
    tbl[1]  = '{"st_and_fetch", 1,1,1, 32'h80,  32'h1234, 32'h40,  0, 0, 0, 2,  5, 32'hDEADBEEF, 32'h93, 0};
    tbl[2]  = '{"load_back",    1,0,0, 32'h80,  32'h0,    32'h0,   1, 0, 0, 3, -1, 32'h1234,     32'h93, 0};
    tbl[3]  = '{"abort_busy2",  0,0,1, 32'h0,   32'h0,    32'h100, 0, 3, 2,-1, -1, 32'h1234,     32'h93, 0};
    tbl[4]  = '{"fetch_lat0",   0,0,1, 32'h0,   32'h0,    32'h100, 0, 0, 0,-1,  2, 32'h1234,     32'h13, 0};
    tbl[5]  = '{"abort_done",   0,0,1, 32'h0,   32'h0,    32'h100, 0, 2, 4,-1, -1, 32'h1234,     32'h13, 0};
    tbl[6]  = '{"abort_ack",    0,0,1, 32'h0,   32'h0,    32'h40,  0, 1, 2,-1, -1, 32'h1234,     32'h13, 0};
    tbl[7]  = '{"ack_on_last",  1,0,0, 32'h10,  32'h0,    32'h0,   7, 0, 0, 9, -1, 32'hDEADBEEF, 32'h13, 0};
    tbl[8]  = '{"timeout_ld",   1,0,0, 32'h80,  32'h0,    32'h0,  99, 0, 0, 9, -1, 32'h0,        32'h13, 1};
    tbl[9]  = '{"err_sticky",   1,0,0, 32'h10,  32'h0,    32'h0,   0, 0, 0, 2, -1, 32'hDEADBEEF, 32'h13, 1};
    tbl[10] = '{"timeout_if",   0,0,1, 32'h0,   32'h0,    32'h40,  0,99, 0,-1,  9, 32'hDEADBEEF, 32'h0,  1};

    resp_mem[32'h10] = 32'hDEADBEEF;  ref_mem[32'h10] = 32'hDEADBEEF;
    resp_mem[32'h40] = 32'h00000093;  ref_mem[32'h40] = 32'h00000093;
    resp_mem[32'h100] = 32'h00000013; ref_mem[32'h100] = 32'h00000013;

    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_abort_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst.mem_req", bus.mem_req_o, 0);
    chk("rst.dm_ready", bus.dm_ready_o, 0);
    chk("rst.if_ready", bus.if_ready_o, 0);
    chk("rst.err", bus.err_o, 0);
    chk("rst.dm_rdata", bus.dm_rdata_o, 0);
    chk("rst.if_rdata", bus.if_rdata_o, 0);
    chk("rst.stall", bus.stall_o, 0);

    foreach (tbl[i]) begin
      model(tbl[i].dm, tbl[i].we, tbl[i].fe, tbl[i].da, tbl[i].wd, tbl[i].ia,
            tbl[i].ld, tbl[i].li, tbl[i].ab, edc, eic);
      run_scn(tbl[i].nm, tbl[i].dm, tbl[i].we, tbl[i].fe, tbl[i].da, tbl[i].wd, tbl[i].ia,
              tbl[i].ld, tbl[i].li, tbl[i].ab, tbl[i].edc, tbl[i].eic,
              tbl[i].edr, tbl[i].eir, tbl[i].eerr);
    end

    // Reset in the 2nd BUSY_D cycle of a load that would otherwise time out.
    lat_q.delete();
    lat_q.push_back(99);
    @(negedge clk_i);
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h20;
    @(negedge clk_i); #1;
    chk("midrst.busy_before", bus.mem_req_o, 1);
    chk("midrst.err_before", bus.err_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; bus.dm_req_i = 0;
    #1;
    chk("midrst.mem_req", bus.mem_req_o, 0);
    chk("midrst.err", bus.err_o, 0);
    chk("midrst.dm_rdata", bus.dm_rdata_o, 0);
    edc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); #1;
      if (bus.dm_ready_o === 1'b1 || bus.mem_req_o === 1'b1) edc++;
    end
    chk("midrst.quiet", edc, 0);
    ref_dr = '0; ref_ir = '0; ref_err = 1'b0;
    model(1, 0, 0, 32'h10, 0, 0, 1, 0, 0, edc, eic);
    run_scn("after_rst", 1, 0, 0, 32'h10, 0, 0, 1, 0, 0, 3, -1, 32'hDEADBEEF, 32'h0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 2);
      dm = (mode != 1);
      fe = (mode != 0);
      we = $urandom_range(0, 1);
      da = 32'($urandom_range(0, 31)) << 2;
      ia = 32'($urandom_range(0, 31)) << 2;
      wd = $urandom;
      ld = $urandom_range(0, 9);
      li = $urandom_range(0, 9);
      ab = (mode == 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 1 + eff(li)) : 0;
      model(dm, we, fe, da, wd, ia, ld, li, ab, edc, eic);
      run_scn($sformatf("rnd%0d", n), dm, we, fe, da, wd, ia, ld, li, ab,
              edc, eic, ref_dr, ref_ir, ref_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
